// File: rtl/dwnsmp_pkg.sv
// Shared defaults and phase-width derivation for the downsampler and the RRC filter blocks.
package dwnsmp_pkg;

  localparam int OS_DEF   = 4;
  localparam int N_CH_DEF = 2;
  localparam int S_IN_DEF = 10;

  // A 1-bit phase index is kept even for degenerate factors so vectors never collapse to zero width.
  function automatic int ph_width(input int os);
    return (os > 1) ? $clog2(os) : 1;
  endfunction

endpackage

// File: rtl/dwnsmp_phase_ctr.sv
// Symbol phase tracking: counter with sync realignment, boundary-loaded phase register,
// misaligned-sync detection and the per-sample selection decision.
module dwnsmp_phase_ctr
  import dwnsmp_pkg::*;
#(
  parameter  int OS   = OS_DEF,
  localparam int PH_W = ph_width(OS)
) (
  input  logic            clock,
  input  logic            i_reset,
  input  logic            i_enable,
  input  logic            i_valid,
  input  logic            i_sync,
  input  logic [PH_W-1:0] i_fase,
  output logic            sel,
  output logic [PH_W-1:0] o_fase,
  output logic            o_sync_err
);

  localparam logic [PH_W-1:0] PH_ONE = PH_W'(1);

  logic [PH_W-1:0] cnt;
  logic [PH_W-1:0] eff_phase;
  logic [PH_W-1:0] cmp_phase;
  logic            accept;
  logic            boundary;

  // At a symbol boundary the freshly requested phase applies to that same sample.
  always_comb begin
    accept    = i_enable && i_valid;
    eff_phase = i_sync ? '0 : cnt;
    boundary  = accept && (eff_phase == '0);
    cmp_phase = boundary ? i_fase : o_fase;
    sel       = accept && (eff_phase == cmp_phase);
  end

  // OS is a power of two, so the natural PH_W-bit wrap gives the modulo-OS advance.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      cnt        <= '0;
      o_fase     <= '0;
      o_sync_err <= 1'b0;
    end else begin
      o_sync_err <= accept && i_sync && (cnt != '0);
      if (accept) begin
        cnt <= eff_phase + PH_ONE;
      end
      if (boundary) begin
        o_fase <= i_fase;
      end
    end
  end

endmodule

// File: rtl/dwnsmp_mc.sv
// Multi-channel decimator: keeps one sample per symbol at the selected phase, all channels together.
module dwnsmp_mc
  import dwnsmp_pkg::*;
#(
  parameter  int OS   = OS_DEF,
  parameter  int N_CH = N_CH_DEF,
  parameter  int S_IN = S_IN_DEF,
  localparam int PH_W = ph_width(OS),
  localparam int DW   = N_CH * S_IN
) (
  input  logic            clock,
  input  logic            i_reset,
  input  logic            i_enable,
  input  logic            i_valid,
  input  logic [PH_W-1:0] i_fase,
  input  logic            i_sync,
  input  logic [DW-1:0]   i_data,
  output logic [DW-1:0]   o_data,
  output logic            o_valid,
  output logic [PH_W-1:0] o_fase,
  output logic            o_sync_err
);

  logic sel;

  dwnsmp_phase_ctr #(
    .OS(OS)
  ) u_phase_ctr (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_valid    (i_valid),
    .i_sync     (i_sync),
    .i_fase     (i_fase),
    .sel        (sel),
    .o_fase     (o_fase),
    .o_sync_err (o_sync_err)
  );

  // sel already implies an accepted sample, so a disabled cycle clears the strobe and holds data.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= sel;
      if (sel) begin
        o_data <= i_data;
      end
    end
  end

endmodule

// File: tb/tb_dwnsmp_mc.sv
// Directed scenarios plus randomized traffic for dwnsmp_mc, checked against a symbol-level model.
module tb_dwnsmp_mc;

  localparam int OS   = 4;
  localparam int N_CH = 2;
  localparam int S_IN = 10;
  localparam int PH_W = 2;
  localparam int DW   = N_CH * S_IN;

  logic            clock;
  logic            i_reset;
  logic            i_enable;
  logic            i_valid;
  logic [PH_W-1:0] i_fase;
  logic            i_sync;
  logic [DW-1:0]   i_data;
  logic [DW-1:0]   o_data;
  logic            o_valid;
  logic [PH_W-1:0] o_fase;
  logic            o_sync_err;

  int checks;
  int failures;
  int err_cnt;
  int strobe_q[$];
  int exp_q[$];

  // Model state: position inside the current symbol and the applied phase.
  int              m_pos;
  logic [PH_W-1:0] m_fase;
  logic [DW-1:0]   m_data;
  logic            exp_valid;
  logic            exp_err;

  logic          rst, en, vld, syn;
  int            fs;
  int            a;
  logic [DW-1:0] d;

  dwnsmp_mc #(
    .OS  (OS),
    .N_CH(N_CH),
    .S_IN(S_IN)
  ) dut (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_valid    (i_valid),
    .i_fase     (i_fase),
    .i_sync     (i_sync),
    .i_data     (i_data),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_fase     (o_fase),
    .o_sync_err (o_sync_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [DW-1:0] pack2(input int c0, input int c1);
    logic [S_IN-1:0] lo;
    logic [S_IN-1:0] hi;
    lo = c0[S_IN-1:0];
    hi = c1[S_IN-1:0];
    return {hi, lo};
  endfunction

  task automatic model_step(input logic r, input logic e, input logic v, input logic s,
                            input logic [PH_W-1:0] f, input logic [DW-1:0] dat);
    int ph;
    if (r) begin
      m_pos = 0; m_fase = '0; m_data = '0; exp_valid = 1'b0; exp_err = 1'b0;
    end else if (!(e && v)) begin
      exp_valid = 1'b0; exp_err = 1'b0;
    end else begin
      ph      = s ? 0 : m_pos;
      exp_err = s && (m_pos != 0);
      if (ph == 0) m_fase = f;
      exp_valid = (ph == int'(m_fase));
      if (exp_valid) m_data = dat;
      m_pos = (ph + 1) % OS;
    end
  endtask

  task automatic check_output();
    checks++;
    assert (o_valid === exp_valid) else begin
      failures++; $error("[TB] FAIL o_valid observed=%0b expected=%0b", o_valid, exp_valid);
    end
    checks++;
    assert (o_data === m_data) else begin
      failures++; $error("[TB] FAIL o_data observed=%0h expected=%0h", o_data, m_data);
    end
    checks++;
    assert (o_fase === m_fase) else begin
      failures++; $error("[TB] FAIL o_fase observed=%0d expected=%0d", o_fase, m_fase);
    end
    checks++;
    assert (o_sync_err === exp_err) else begin
      failures++; $error("[TB] FAIL o_sync_err observed=%0b expected=%0b", o_sync_err, exp_err);
    end
    if (o_valid === 1'b1) strobe_q.push_back(int'($signed(o_data[S_IN-1:0])));
    if (o_sync_err === 1'b1) err_cnt++;
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++; $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_strobes(input string tag);
    check_val({tag, "_count"}, strobe_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      check_val(tag, (i < strobe_q.size()) ? strobe_q[i] : -99999, exp_q[i]);
    end
    strobe_q.delete();
    exp_q.delete();
  endtask

  task automatic apply_stimulus(input logic r, input logic e, input logic v, input logic s,
                                input int f, input logic [DW-1:0] dat);
    i_reset  = r;
    i_enable = e;
    i_valid  = v;
    i_sync   = s;
    i_fase   = PH_W'(f);
    i_data   = dat;
    @(posedge clock);
    model_step(r, e, v, s, PH_W'(f), dat);
    #1;
    check_output();
  endtask

  initial begin
    checks = 0; failures = 0; err_cnt = 0;
    i_reset = 1'b1; i_enable = 1'b0; i_valid = 1'b0; i_sync = 1'b0; i_fase = '0; i_data = '0;

    $display("[TB] reset");
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 3, pack2(7, 7));
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, '0);

    $display("[TB] ramp with aligned sync, phase 2");
    for (int s = 0; s < 16; s++) apply_stimulus(1'b0, 1'b1, 1'b1, (s % 4) == 0, 2, pack2(s, s));
    exp_q = '{2, 6, 10, 14};
    check_strobes("ramp");

    $display("[TB] phase request 1 -> 3 mid-symbol");
    for (int s = 0; s < 16; s++)
      apply_stimulus(1'b0, 1'b1, 1'b1, (s % 4) == 0, (s < 5) ? 1 : 3, pack2(s, -s));
    exp_q = '{1, 5, 11, 15};
    check_strobes("phase_change");

    $display("[TB] early sync");
    err_cnt = 0;
    for (int s = 0; s < 14; s++)
      apply_stimulus(1'b0, 1'b1, 1'b1, (s == 0) || (s == 4) || (s == 6) || (s == 10), 1, pack2(s, s));
    exp_q = '{1, 5, 7, 11};
    check_strobes("early_sync");
    check_val("sync_err_pulses", err_cnt, 1);

    $display("[TB] valid and enable gaps");
    a = 0;
    for (int c = 0; c < 21; c++) begin
      if (c >= 3 && c <= 5) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, DW'($urandom));
      else if (c == 9 || c == 10) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1, DW'($urandom));
      else begin
        apply_stimulus(1'b0, 1'b1, 1'b1, (a % 4) == 0, 0, pack2(a, 3 * a));
        a++;
      end
    end
    exp_q = '{0, 4, 8, 12};
    check_strobes("gaps");

    $display("[TB] full-scale signed samples");
    for (int s = 0; s < 4; s++) begin
      apply_stimulus(1'b0, 1'b1, 1'b1, s == 0, 2, (s == 2) ? pack2(-512, 511) : DW'($urandom));
      if (s == 2) begin
        check_val("ch0_signed", int'($signed(o_data[S_IN-1:0])), -512);
        check_val("ch1_signed", int'($signed(o_data[DW-1:S_IN])), 511);
      end
    end
    strobe_q.delete();

    $display("[TB] reset mid-symbol");
    for (int s = 0; s < 6; s++) apply_stimulus(1'b0, 1'b1, 1'b1, (s % 4) == 0, 3, pack2(s, s));
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 3, pack2(9, 9));
    check_val("rst_data", int'(o_data), 0);
    check_val("rst_valid", int'(o_valid), 0);
    strobe_q.delete();
    for (int s = 0; s < 8; s++) apply_stimulus(1'b0, 1'b1, 1'b1, s == 4, 3, pack2(s + 100, s));
    exp_q = '{103, 107};
    check_strobes("after_reset");

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(99) == 0);
      en  = ($urandom_range(9) != 0);
      vld = ($urandom_range(3) != 0);
      syn = (m_pos == 0) ? ($urandom_range(4) != 0) : ($urandom_range(29) == 0);
      fs  = int'($urandom_range(OS - 1));
      d   = DW'($urandom);
      apply_stimulus(rst, en, vld, syn, fs, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dwnsmp_mc.md
DWNSMP_MC -- requirements
Module: dwnsmp_mc

Interface
REQ-001 Parameter OS, default 4, oversampling factor; power of two, 2..16.
REQ-002 Parameter N_CH, default 2, number of parallel channels (e.g. I/Q).
REQ-003 Parameter S_IN, default 10, signed sample width per channel.
REQ-004 Derived constant PH_W = clog2(OS), phase index width.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clock  in  1  sole clock, all state on rising edge.
REQ-007 i_reset  in  1  synchronous active-high reset.
REQ-008 i_enable  in  1  global clock enable; low freezes all state.
REQ-009 i_valid  in  1  input sample strobe; a sample is accepted when i_enable and i_valid are both high.
REQ-010 i_fase  in  PH_W  requested decimation phase, 0..OS-1.
REQ-011 i_sync  in  1  marks the accepted sample as phase 0 of a symbol.
REQ-012 i_data  in  N_CH*S_IN  packed signed samples, channel 0 in LSBs.
REQ-013 o_data  out  N_CH*S_IN  decimated samples, same packing.
REQ-014 o_valid  out  1  one-cycle strobe, o_data updated.
REQ-015 o_fase  out  PH_W  phase currently applied.
REQ-016 o_sync_err  out  1  one-cycle strobe, i_sync arrived misaligned.

Function
REQ-017 Phase counter cnt advances by one per accepted sample, wrapping OS-1 -> 0; unchanged otherwise.
REQ-018 Effective phase of an accepted sample: 0 if i_sync high, else cnt; after it, cnt = effective phase + 1 mod OS.
REQ-019 i_fase is loaded into the phase register (o_fase) only on an accepted sample with effective phase 0; mid-symbol i_fase changes are ignored until the next boundary.
REQ-020 Selection compares the effective phase with i_fase at a boundary sample, else with o_fase.
REQ-021 On selection, o_data captures all channels bit-exact, o_valid high the next cycle for exactly one cycle (latency 1).
REQ-022 Exactly one o_valid per OS accepted samples while i_sync stays aligned; none when i_valid is low.
REQ-023 o_data holds its value between strobes.
REQ-024 o_sync_err pulses one cycle after an accepted i_sync whose cnt was not 0; cnt still realigns.
REQ-025 i_enable low: cnt, o_fase and o_data hold; o_valid and o_sync_err forced 0 next cycle.
REQ-026 i_sync or i_valid while i_enable low has no effect.
REQ-027 Phase change at a boundary may yield one symbol with a gap of up to 2*OS-1 samples, never two strobes within one symbol.

Reset
REQ-028 i_reset high at a rising edge: cnt=0, o_fase=0, o_data=0, o_valid=0, o_sync_err=0.
REQ-029 Reset has priority over i_enable, i_valid and i_sync in the same cycle.
REQ-030 Reset mid-symbol discards the partial symbol; first accepted sample after reset has effective phase 0.

Structure
REQ-031 Package dwnsmp_pkg holds default OS, N_CH, S_IN and the PH_W derivation, shared with dwnsmp and the RRC filter blocks.
REQ-032 Sub-module dwnsmp_phase_ctr holds cnt, sync realignment, phase register and sync-error detection; the top holds the data registers.

Verification (OS=4, N_CH=2, S_IN=10)
REQ-033 Ramp 0..15 on both channels, i_sync on samples 0,4,8,12, i_fase=2 -> o_data=2,6,10,14, four strobes, each one cycle after its sample.
REQ-034 i_fase 1 -> 3 asserted at sample 5 -> outputs 1,5, then 11,15 (change effective at sample 8).
REQ-035 i_sync at sample 6 instead of 8 -> o_sync_err pulse after sample 6; next selection at sample 6+i_fase.
REQ-036 i_valid low on samples 3-5, i_enable low 2 cycles mid-stream -> no strobes during gaps, o_data held, cnt resumes.
REQ-037 Ch0=-512, ch1=+511 on selected phase -> o_data bit-exact both channels, no sign corruption.
REQ-038 i_reset at sample 6 with i_valid high -> all outputs 0 next cycle; next accepted sample is phase 0.
